// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bundle: PC adder loop, redirect/stall controls, imem handshake and decode output.
// master = fetch unit side, slave = surrounding datapath / memory / decode side.
interface pc_fetch_unit_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 32
);
  logic [ADDR_W-1:0]  address;
  logic [ADDR_W-1:0]  PC;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;
  logic               stall;
  logic               imem_req;
  logic               imem_ready;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               pc_wrap;

  modport master (
    output address, imem_req, instr, instr_valid, pc_wrap,
    input  PC, branch_taken, branch_target, stall, imem_ready, imem_rdata
  );

  modport slave (
    input  address, imem_req, instr, instr_valid, pc_wrap,
    output PC, branch_taken, branch_target, stall, imem_ready, imem_rdata
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register + fetch sequencer; optional sticky wrap detector under PC_WRAP_CHECK_EN.
// Latency: instr valid one cycle after the imem_req && imem_ready handshake; 1 instr/cycle.
// Backpressure: imem_ready low or stall high holds the PC; branch_taken overrides both.
module pc_fetch_unit #(
  parameter int                ADDR_W     = 16,
  parameter int                INSTR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic             clk,
  input  logic             rst,
  pc_fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {IDLE, FETCH, STALL} state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  addr_q, addr_nxt;
  logic [INSTR_W-1:0] instr_q, instr_nxt;
  logic               vld_q, vld_nxt;
  logic               req;
  logic               hs;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      addr_q  <= RESET_ADDR;
      instr_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      addr_q  <= addr_nxt;
      instr_q <= instr_nxt;
      vld_q   <= vld_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    instr_nxt = instr_q;
    vld_nxt   = vld_q;
    req       = (state == FETCH) && !bus.stall && !bus.branch_taken;
    hs        = req && bus.imem_ready;

    case (state)
      IDLE:         state_nxt = FETCH;
      FETCH, STALL: state_nxt = bus.stall ? STALL : FETCH;
      default:      state_nxt = IDLE;
    endcase

    if (bus.branch_taken) begin
      state_nxt = FETCH;
      addr_nxt  = bus.branch_target;
      vld_nxt   = 1'b0;
    end else if (hs) begin
      instr_nxt = bus.imem_rdata;
      vld_nxt   = 1'b1;
      addr_nxt  = bus.PC;
    end else if (!bus.stall) begin
      // Leaving STALL or an idle FETCH cycle: no new word, so nothing is re-presented.
      vld_nxt = 1'b0;
    end
  end

  assign bus.address     = addr_q;
  assign bus.imem_req    = req;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = vld_q;

`ifdef PC_WRAP_CHECK_EN
  logic wrap_q, wrap_nxt;

  always_comb begin
    wrap_nxt = wrap_q;
    if (bus.branch_taken)
      wrap_nxt = 1'b0;
    else if (hs && (bus.PC < addr_q))
      wrap_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) wrap_q <= 1'b0;
    else      wrap_q <= wrap_nxt;
  end

  assign bus.pc_wrap = wrap_q;
`else
  assign bus.pc_wrap = 1'b0;
`endif

endmodule
